// File: rtl/instruction_fetch.sv
// Fetch stage: owns the program counter, reads the instruction ROM and holds the IF/ID register
// with a valid/ready handshake toward decode, plus redirect, halt/resume and a fetch counter.
module instruction_fetch #(
  parameter logic [7:0]  RESET_PC = 8'h00,
  parameter logic [15:0] NOP_WORD = 16'h2800
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  pc_out,
  input  logic [15:0] instr_in,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [15:0] id_instr,
  output logic [7:0]  id_pc,
  output logic [7:0]  id_pc_plus1,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_target,
  input  logic        halt_req,
  input  logic        resume_req,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic {StRun, StHalted} state_e;

  state_e      r_state, w_state_d;
  logic [7:0]  r_pc, w_pc_d;
  logic        r_id_valid, w_id_valid_d;
  logic [15:0] r_id_instr, w_id_instr_d;
  logic [7:0]  r_id_pc, w_id_pc_d;
  logic [15:0] r_fetch_count, w_fetch_count_d;
  logic        w_fetch_fire;

  // Halt/resume run independently of redirect; a redirect never changes the state.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StRun:    if (halt_req)   w_state_d = StHalted;
      StHalted: if (resume_req) w_state_d = StRun;
      default:  w_state_d = StRun;
    endcase
  end

  assign w_fetch_fire = (r_state == StRun) && !halt_req && !redirect_valid &&
                        (!r_id_valid || id_ready);

  always_comb begin
    w_pc_d          = r_pc;
    w_id_valid_d    = r_id_valid;
    w_id_instr_d    = r_id_instr;
    w_id_pc_d       = r_id_pc;
    w_fetch_count_d = r_fetch_count;
    if (redirect_valid) begin
      // Flush wins even if decode signals ready this cycle.
      w_pc_d       = redirect_target;
      w_id_valid_d = 1'b0;
      w_id_instr_d = NOP_WORD;
    end else if (w_fetch_fire) begin
      w_id_instr_d = instr_in;
      w_id_pc_d    = r_pc;
      w_id_valid_d = 1'b1;
      w_pc_d       = r_pc + 8'd1;
      if (r_fetch_count != 16'hFFFF) w_fetch_count_d = r_fetch_count + 16'd1;
    end else if (r_id_valid && id_ready) begin
      w_id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StRun;
      r_pc          <= RESET_PC;
      r_id_valid    <= 1'b0;
      r_id_instr    <= NOP_WORD;
      r_id_pc       <= 8'h00;
      r_fetch_count <= 16'h0000;
    end else begin
      r_state       <= w_state_d;
      r_pc          <= w_pc_d;
      r_id_valid    <= w_id_valid_d;
      r_id_instr    <= w_id_instr_d;
      r_id_pc       <= w_id_pc_d;
      r_fetch_count <= w_fetch_count_d;
    end
  end

  assign pc_out      = r_pc;
  assign id_valid    = r_id_valid;
  assign id_instr    = r_id_instr;
  assign id_pc       = r_id_pc;
  assign id_pc_plus1 = r_id_pc + 8'd1;
  assign halted      = (r_state == StHalted);
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed table-driven bench for instruction_fetch with a combinational ROM model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pc_out;
  logic [15:0] instr_in;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [15:0] id_instr;
  logic [7:0]  id_pc;
  logic [7:0]  id_pc_plus1;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_target = 8'h00;
  logic        halt_req = 1'b0;
  logic        resume_req = 1'b0;
  logic        halted;
  logic [15:0] fetch_count;

  int total = 0;
  int bad = 0;

  localparam logic [15:0] Nop = 16'h2800;

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [7:0] a);
    case (a)
      8'h00:   rom_word = 16'h4001;
      8'h01:   rom_word = 16'h4102;
      8'h02:   rom_word = 16'h8010;
      8'h03:   rom_word = 16'h2800;
      default: rom_word = {~a, a};
    endcase
  endfunction

  assign instr_in = rom_word(pc_out);

  instruction_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .pc_out          (pc_out),
    .instr_in        (instr_in),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .id_pc_plus1     (id_pc_plus1),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt_req        (halt_req),
    .resume_req      (resume_req),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  typedef struct {
    logic        rst, rdy, rv;
    logic [7:0]  rt;
    logic        hr, rr;
    logic [7:0]  pc;
    logic        v;
    logic [15:0] instr;
    logic [7:0]  idpc;
    logic        h;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[32];

  function automatic vec_t mk(input logic rst_v, input logic rdy, input logic rv,
                              input logic [7:0] rt, input logic hr, input logic rr,
                              input logic [7:0] pc, input logic v, input logic [15:0] instr,
                              input logic [7:0] idpc, input logic h, input logic [15:0] cnt);
    vec_t t;
    t.rst = rst_v; t.rdy = rdy; t.rv = rv; t.rt = rt; t.hr = hr; t.rr = rr;
    t.pc = pc; t.v = v; t.instr = instr; t.idpc = idpc; t.h = h; t.cnt = cnt;
    return t;
  endfunction

  task automatic check(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input int idx, input logic [7:0] pc, input logic v,
                           input logic [15:0] instr, input logic [7:0] idpc, input logic h,
                           input logic [15:0] cnt);
    logic [7:0] plus1;
    plus1 = idpc + 8'd1;
    check("pc_out", idx, {8'h00, pc_out}, {8'h00, pc});
    check("id_valid", idx, {15'h0, id_valid}, {15'h0, v});
    check("id_instr", idx, id_instr, instr);
    check("id_pc", idx, {8'h00, id_pc}, {8'h00, idpc});
    check("id_pc_plus1", idx, {8'h00, id_pc_plus1}, {8'h00, plus1});
    check("halted", idx, {15'h0, halted}, {15'h0, h});
    check("fetch_count", idx, fetch_count, cnt);
  endtask

  initial begin
    bit found;
    //              rst rdy rv rt    hr rr  pc     v  instr            idpc   h  cnt
    vecs[0]  = mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, Nop,             8'h00, 0, 16'd0);
    vecs[1]  = mk(0, 1, 0, 8'h00, 0, 0, 8'h01, 1, rom_word(8'h00), 8'h00, 0, 16'd1);
    vecs[2]  = mk(0, 1, 0, 8'h00, 0, 0, 8'h02, 1, rom_word(8'h01), 8'h01, 0, 16'd2);
    vecs[3]  = mk(0, 1, 0, 8'h00, 0, 0, 8'h03, 1, rom_word(8'h02), 8'h02, 0, 16'd3);
    vecs[4]  = mk(0, 0, 0, 8'h00, 0, 0, 8'h03, 1, rom_word(8'h02), 8'h02, 0, 16'd3);
    vecs[5]  = mk(0, 0, 0, 8'h00, 0, 0, 8'h03, 1, rom_word(8'h02), 8'h02, 0, 16'd3);
    vecs[6]  = mk(0, 0, 0, 8'h00, 0, 0, 8'h03, 1, rom_word(8'h02), 8'h02, 0, 16'd3);
    vecs[7]  = mk(0, 1, 0, 8'h00, 0, 0, 8'h04, 1, rom_word(8'h03), 8'h03, 0, 16'd4);
    vecs[8]  = mk(0, 1, 0, 8'h00, 0, 0, 8'h05, 1, rom_word(8'h04), 8'h04, 0, 16'd5);
    vecs[9]  = mk(0, 0, 0, 8'h00, 0, 0, 8'h05, 1, rom_word(8'h04), 8'h04, 0, 16'd5);
    // Redirect during a stall, then during free-running fetch with wrap.
    vecs[10] = mk(0, 0, 1, 8'h40, 0, 0, 8'h40, 0, Nop,             8'h04, 0, 16'd5);
    vecs[11] = mk(0, 0, 0, 8'h00, 0, 0, 8'h41, 1, rom_word(8'h40), 8'h40, 0, 16'd6);
    vecs[12] = mk(0, 1, 0, 8'h00, 0, 0, 8'h42, 1, rom_word(8'h41), 8'h41, 0, 16'd7);
    vecs[13] = mk(0, 1, 1, 8'hFE, 0, 0, 8'hFE, 0, Nop,             8'h41, 0, 16'd7);
    vecs[14] = mk(0, 1, 0, 8'h00, 0, 0, 8'hFF, 1, rom_word(8'hFE), 8'hFE, 0, 16'd8);
    vecs[15] = mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 1, rom_word(8'hFF), 8'hFF, 0, 16'd9);
    vecs[16] = mk(0, 1, 0, 8'h00, 0, 0, 8'h01, 1, rom_word(8'h00), 8'h00, 0, 16'd10);
    vecs[17] = mk(0, 1, 0, 8'h00, 0, 0, 8'h02, 1, rom_word(8'h01), 8'h01, 0, 16'd11);
    // Halt during a stall; held instruction drains, then resume.
    vecs[18] = mk(0, 0, 0, 8'h00, 1, 0, 8'h02, 1, rom_word(8'h01), 8'h01, 1, 16'd11);
    vecs[19] = mk(0, 0, 0, 8'h00, 0, 0, 8'h02, 1, rom_word(8'h01), 8'h01, 1, 16'd11);
    vecs[20] = mk(0, 1, 0, 8'h00, 0, 0, 8'h02, 0, rom_word(8'h01), 8'h01, 1, 16'd11);
    vecs[21] = mk(0, 1, 0, 8'h00, 0, 0, 8'h02, 0, rom_word(8'h01), 8'h01, 1, 16'd11);
    vecs[22] = mk(0, 1, 0, 8'h00, 0, 1, 8'h02, 0, rom_word(8'h01), 8'h01, 0, 16'd11);
    vecs[23] = mk(0, 1, 0, 8'h00, 0, 0, 8'h03, 1, rom_word(8'h02), 8'h02, 0, 16'd12);
    // Halt with ready; then simultaneous halt+resume while halted resumes.
    vecs[24] = mk(0, 1, 0, 8'h00, 1, 0, 8'h03, 0, rom_word(8'h02), 8'h02, 1, 16'd12);
    vecs[25] = mk(0, 1, 0, 8'h00, 1, 1, 8'h03, 0, rom_word(8'h02), 8'h02, 0, 16'd12);
    vecs[26] = mk(0, 1, 0, 8'h00, 0, 0, 8'h04, 1, rom_word(8'h03), 8'h03, 0, 16'd13);
    // Redirect while halted keeps the halted state.
    vecs[27] = mk(0, 0, 0, 8'h00, 1, 0, 8'h04, 1, rom_word(8'h03), 8'h03, 1, 16'd13);
    vecs[28] = mk(0, 0, 1, 8'h10, 0, 0, 8'h10, 0, Nop,             8'h03, 1, 16'd13);
    vecs[29] = mk(0, 0, 0, 8'h00, 0, 1, 8'h10, 0, Nop,             8'h03, 0, 16'd13);
    vecs[30] = mk(0, 1, 0, 8'h00, 0, 0, 8'h11, 1, rom_word(8'h10), 8'h10, 0, 16'd14);
    vecs[31] = mk(0, 1, 0, 8'h00, 0, 0, 8'h12, 1, rom_word(8'h11), 8'h11, 0, 16'd15);

    step();
    for (int i = 0; i < 32; i++) begin
      rst             = vecs[i].rst;
      id_ready        = vecs[i].rdy;
      redirect_valid  = vecs[i].rv;
      redirect_target = vecs[i].rt;
      halt_req        = vecs[i].hr;
      resume_req      = vecs[i].rr;
      step();
      check_all(i, vecs[i].pc, vecs[i].v, vecs[i].instr, vecs[i].idpc, vecs[i].h, vecs[i].cnt);
    end

    // Mid-stream reset with pc=8'h37 and a valid instruction held.
    redirect_valid  = 1'b1;
    redirect_target = 8'h30;
    id_ready        = 1'b1;
    halt_req        = 1'b0;
    resume_req      = 1'b0;
    step();
    redirect_valid = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      step();
      if (pc_out == 8'h37) found = 1'b1;
    end
    check("reach_pc37", 100, {15'h0, found}, 16'h0001);
    check("pre_rst_valid", 100, {15'h0, id_valid}, 16'h0001);
    check("pre_rst_idpc", 100, {8'h00, id_pc}, 16'h0036);
    rst = 1'b1;
    step();
    check_all(101, 8'h00, 1'b0, Nop, 8'h00, 1'b0, 16'd0);
    rst = 1'b0;
    step();
    check_all(102, 8'h01, 1'b1, rom_word(8'h00), 8'h00, 1'b0, 16'd1);

    // Reset overrides a simultaneous redirect and halt.
    rst             = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 8'h80;
    halt_req        = 1'b1;
    step();
    check_all(103, 8'h00, 1'b0, Nop, 8'h00, 1'b0, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
